instr_exec_lite: RTL and testbench

//  Execution-side responder to the decode interface: consumes pdp_mem_opcode / pdp_op7_opcode, holds stall

---
 rtl/instr_exec_lite.sv | 327 ++++++++++++++++++++++++++++++++
 tb/tb_instr_exec_lite.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_exec_lite.sv
// -----------------------------------------------------------------------------
// instr_exec_lite
//   Execution-side responder for a PDP-8 style decode stage. Accepts one
//   memory-reference or op7 group-1 instruction at a time while idle, holds
//   stall high while it runs, talks to memory through one-cycle read/write
//   strobes, and maintains PC, AC and link.
//
// Parameters
//   MEM_LAT     exec_rd_data is valid MEM_LAT cycles after exec_rd_req (1..4)
//   OP7_CYCLES  stall cycles taken by an executed op7 microinstruction (>=1)
//
// Ports
//   clk, reset_n         clock; synchronous active-low reset
//   base_addr            start PC, loaded in the INIT cycle after reset
//   pdp_mem_opcode       packed pdp_mem_opcode_s (one-hot flags + address)
//   pdp_op7_opcode       packed pdp_op7_opcode_s (microinstruction flags)
//   stall                1 while busy; opcode inputs ignored
//   PC_value             program counter
//   exec_rd_req/addr     one-cycle read strobe and its address
//   exec_rd_data         read data
//   exec_wr_req/addr/data one-cycle write strobe, address and data
//   ac_out, link_out     accumulator and link
//   retire_cnt           saturating retired-instruction count (only when
//                        EXEC_RETIRE_CNT_EN is defined)
//
// Configuration macro: EXEC_RETIRE_CNT_EN
// -----------------------------------------------------------------------------
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

package instr_exec_lite_pkg;
  localparam int ADDR_W = `ADDR_WIDTH;
  localparam int DATA_W = `DATA_WIDTH;

  typedef struct packed {
    logic              and_op;
    logic              tad;
    logic              isz;
    logic              dca;
    logic              jms;
    logic              jmp;
    logic [ADDR_W-1:0] mem_inst_addr;
  } pdp_mem_opcode_s;

  typedef struct packed {
    logic nop;
    logic iac;
    logic ral;
    logic rtl;
    logic rar;
    logic rtr;
    logic cml;
    logic cma;
    logic cia;
    logic cll;
    logic cla1;
    logic cla_cll;
    logic cla2;
    logic hlt;
    logic osr;
    logic skp;
    logic snl;
    logic szl;
    logic sza;
    logic sna;
    logic sma;
    logic spa;
  } pdp_op7_opcode_s;

  localparam int MEM_OP_W = $bits(pdp_mem_opcode_s);
  localparam int OP7_W    = $bits(pdp_op7_opcode_s);

  // Group-1 flags this block executes; everything else in op7 is a NOP.
  localparam pdp_op7_opcode_s OP7_EXEC_MASK = '{
    iac: 1'b1, ral: 1'b1, rtl: 1'b1, rar: 1'b1, rtr: 1'b1, cml: 1'b1,
    cma: 1'b1, cia: 1'b1, cll: 1'b1, cla1: 1'b1, cla_cll: 1'b1,
    default: 1'b0};
endpackage

module instr_exec_lite
  import instr_exec_lite_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int OP7_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [MEM_OP_W-1:0] pdp_mem_opcode,
  input  logic [OP7_W-1:0]    pdp_op7_opcode,
  output logic                stall,
  output logic [ADDR_W-1:0]   PC_value,
  output logic                exec_rd_req,
  output logic [ADDR_W-1:0]   exec_rd_addr,
  input  logic [DATA_W-1:0]   exec_rd_data,
  output logic                exec_wr_req,
  output logic [ADDR_W-1:0]   exec_wr_addr,
  output logic [DATA_W-1:0]   exec_wr_data,
  output logic [DATA_W-1:0]   ac_out,
  output logic                link_out
`ifdef EXEC_RETIRE_CNT_EN
  ,
  output logic [31:0]         retire_cnt
`endif
);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD, S_WAIT, S_EXEC, S_WR, S_DONE} state_e;
  typedef enum logic [2:0] {K_AND, K_TAD, K_ISZ, K_DCA, K_JMS, K_JMP, K_OP7, K_NOP} kind_e;

  // Only the executable op7 flags are kept once an instruction is accepted.
  typedef struct packed {
    logic cla_cll, cla, cll, cma, cml, iac, cia, ral, rar, rtl, rtr;
  } op7x_s;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(MEM_LAT - 2);
  localparam logic [CNT_W-1:0] OP7_LOAD  = CNT_W'(OP7_CYCLES - 2);

  state_e            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  kind_e             kind, dec_kind;
  logic              dec_valid;
  logic [ADDR_W-1:0] pc, pc_nxt, pc_inc, inst_addr;
  logic [DATA_W-1:0] ac, ac_nxt, mem_data, isz_val, wr_data_c;
  logic              link, link_nxt;
  logic [DATA_W:0]   tad_sum;
  op7x_s             op7_q;

  pdp_mem_opcode_s   mem_op;
  pdp_op7_opcode_s   op7_in;
  logic [5:0]        mem_flags;

  assign mem_op    = pdp_mem_opcode;
  assign op7_in    = pdp_op7_opcode;
  assign mem_flags = {mem_op.and_op, mem_op.tad, mem_op.isz, mem_op.dca, mem_op.jms, mem_op.jmp};

  // Decode of the IDLE sample. A nonzero mem flag field wins over op7.
  always_comb begin
    // NOTE: every variable written here gets a default first so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    dec_valid = 1'b0;
    dec_kind  = K_NOP;
    if (mem_flags != '0) begin
      dec_valid = 1'b1;
      if ($onehot(mem_flags)) begin
        if      (mem_op.and_op) dec_kind = K_AND;
        else if (mem_op.tad)    dec_kind = K_TAD;
        else if (mem_op.isz)    dec_kind = K_ISZ;
        else if (mem_op.dca)    dec_kind = K_DCA;
        else if (mem_op.jms)    dec_kind = K_JMS;
        else                    dec_kind = K_JMP;
      end
    end else if (op7_in != '0) begin
      dec_valid = 1'b1;
      if ($onehot(op7_in) && ((op7_in & OP7_EXEC_MASK) != '0)) dec_kind = K_OP7;
    end
  end

  // Next-state logic. cnt holds the remaining extra cycles in WAIT/EXEC.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_INIT: state_nxt = S_IDLE;
      S_IDLE:
        if (dec_valid) begin
          case (dec_kind)
            K_AND, K_TAD, K_ISZ: state_nxt = S_RD;
            K_DCA, K_JMS:        state_nxt = S_WR;
            K_OP7:
              if (OP7_CYCLES > 1) begin
                state_nxt = S_EXEC;
                cnt_nxt   = OP7_LOAD;
              end else begin
                state_nxt = S_DONE;
              end
            default:             state_nxt = S_DONE;
          endcase
        end
      S_RD:
        if (MEM_LAT > 1) begin
          state_nxt = S_WAIT;
          cnt_nxt   = WAIT_LOAD;
        end else begin
          state_nxt = S_EXEC;
        end
      S_WAIT:
        if (cnt == '0) state_nxt = S_EXEC;
        else           cnt_nxt   = cnt - 1'b1;
      S_EXEC:
        if (kind == K_OP7) begin
          if (cnt == '0) state_nxt = S_DONE;
          else           cnt_nxt   = cnt - 1'b1;
        end else if (kind == K_ISZ) begin
          state_nxt = S_WR;
        end else begin
          state_nxt = S_DONE;
        end
      S_WR:    state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      state <= S_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // op7 group-1 on the 13-bit {link, AC}; exactly one flag is set.
  function automatic logic [DATA_W:0] op7_exec(input op7x_s f, input logic l,
                                                input logic [DATA_W-1:0] a);
    logic [DATA_W:0] v, s;
    v = {l, a};
    s = '0;
    if (f.cla_cll)  v = '0;
    else if (f.cla) v[DATA_W-1:0] = '0;
    else if (f.cll) v[DATA_W] = 1'b0;
    else if (f.cma) v[DATA_W-1:0] = ~a;
    else if (f.cml) v[DATA_W] = ~l;
    else if (f.iac || f.cia) begin
      // Carry out of the increment toggles link rather than replacing it.
      s = {1'b0, (f.cia ? ~a : a)} + 1'b1;
      v = {l ^ s[DATA_W], s[DATA_W-1:0]};
    end
    else if (f.ral) v = {v[DATA_W-1:0], v[DATA_W]};
    else if (f.rar) v = {v[0], v[DATA_W:1]};
    else if (f.rtl) v = {v[DATA_W-2:0], v[DATA_W:DATA_W-1]};
    else if (f.rtr) v = {v[1:0], v[DATA_W:2]};
    return v;
  endfunction

  // Commit values applied in DONE, plus the write data used in WR.
  always_comb begin
    pc_inc    = pc + 1'b1;
    isz_val   = mem_data + 1'b1;
    tad_sum   = {1'b0, ac} + {1'b0, mem_data};
    pc_nxt    = pc_inc;
    ac_nxt    = ac;
    link_nxt  = link;
    wr_data_c = '0;
    case (kind)
      K_AND: ac_nxt = ac & mem_data;
      K_TAD: begin
        ac_nxt   = tad_sum[DATA_W-1:0];
        link_nxt = link ^ tad_sum[DATA_W];
      end
      K_ISZ: begin
        wr_data_c = isz_val;
        if (isz_val == '0) pc_nxt = pc + ADDR_W'(2);
      end
      K_DCA: begin
        wr_data_c = ac;
        ac_nxt    = '0;
      end
      K_JMS: begin
        wr_data_c = DATA_W'(pc_inc);
        pc_nxt    = inst_addr + 1'b1;
      end
      K_JMP:   pc_nxt = inst_addr;
      K_OP7:   {link_nxt, ac_nxt} = op7_exec(op7_q, link, ac);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: reset aborts any in-flight instruction; since WR is only reached
    // through the state register, a pending write is simply never issued.
    if (!reset_n) begin
      pc        <= '0;
      ac        <= '0;
      link      <= 1'b0;
      kind      <= K_NOP;
      inst_addr <= '0;
      op7_q     <= '0;
      mem_data  <= '0;
`ifdef EXEC_RETIRE_CNT_EN
      retire_cnt <= '0;
`endif
    end else begin
      case (state)
        S_INIT: pc <= base_addr;
        S_IDLE:
          if (dec_valid) begin
            kind      <= dec_kind;
            inst_addr <= mem_op.mem_inst_addr;
            op7_q     <= '{cla_cll: op7_in.cla_cll, cla: op7_in.cla1, cll: op7_in.cll,
                           cma: op7_in.cma, cml: op7_in.cml, iac: op7_in.iac,
                           cia: op7_in.cia, ral: op7_in.ral, rar: op7_in.rar,
                           rtl: op7_in.rtl, rtr: op7_in.rtr};
          end
        S_EXEC: if (kind != K_OP7) mem_data <= exec_rd_data;
        S_DONE: begin
          pc   <= pc_nxt;
          ac   <= ac_nxt;
          link <= link_nxt;
`ifdef EXEC_RETIRE_CNT_EN
          if (retire_cnt != 32'hFFFF_FFFF) retire_cnt <= retire_cnt + 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  assign stall        = (state != S_IDLE);
  assign PC_value     = pc;
  assign ac_out       = ac;
  assign link_out     = link;
  assign exec_rd_req  = (state == S_RD);
  assign exec_rd_addr = (state == S_RD) ? inst_addr : '0;
  assign exec_wr_req  = (state == S_WR);
  assign exec_wr_addr = (state == S_WR) ? inst_addr : '0;
  assign exec_wr_data = (state == S_WR) ? wr_data_c : '0;

endmodule

// File: tb/tb_instr_exec_lite.sv
// -----------------------------------------------------------------------------
// tb_instr_exec_lite
//   Directed self-checking bench for instr_exec_lite (MEM_LAT=1, OP7_CYCLES=2,
//   base_addr=0200). Each issued instruction pushes its expected retirement
//   state onto a scoreboard queue; the entry is popped and compared once the
//   DUT drops stall. A small memory model answers reads one cycle after the
//   strobe and a monitor counts/records read and write strobes.
// -----------------------------------------------------------------------------
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

module tb_instr_exec_lite;
  import instr_exec_lite_pkg::*;

  typedef struct {
    logic [11:0] pc;
    logic [11:0] ac;
    logic        link;
    int          cycles;
    int          rds;
    int          wrs;
  } exp_t;

  localparam logic [5:0] F_AND = 6'b100000, F_TAD = 6'b010000, F_ISZ = 6'b001000,
                         F_DCA = 6'b000100, F_JMS = 6'b000010, F_JMP = 6'b000001;

  localparam pdp_op7_opcode_s O_NONE    = '0;
  localparam pdp_op7_opcode_s O_CLA_CLL = '{cla_cll: 1'b1, default: 1'b0};
  localparam pdp_op7_opcode_s O_CLA     = '{cla1: 1'b1, default: 1'b0};
  localparam pdp_op7_opcode_s O_CLL     = '{cll: 1'b1, default: 1'b0};
  localparam pdp_op7_opcode_s O_CMA     = '{cma: 1'b1, default: 1'b0};
  localparam pdp_op7_opcode_s O_CML     = '{cml: 1'b1, default: 1'b0};
  localparam pdp_op7_opcode_s O_IAC     = '{iac: 1'b1, default: 1'b0};
  localparam pdp_op7_opcode_s O_CIA     = '{cia: 1'b1, default: 1'b0};
  localparam pdp_op7_opcode_s O_RAL     = '{ral: 1'b1, default: 1'b0};
  localparam pdp_op7_opcode_s O_RAR     = '{rar: 1'b1, default: 1'b0};
  localparam pdp_op7_opcode_s O_RTL     = '{rtl: 1'b1, default: 1'b0};
  localparam pdp_op7_opcode_s O_RTR     = '{rtr: 1'b1, default: 1'b0};
  localparam pdp_op7_opcode_s O_SMA     = '{sma: 1'b1, default: 1'b0};
  localparam pdp_op7_opcode_s O_NOP     = '{nop: 1'b1, default: 1'b0};
  localparam pdp_op7_opcode_s O_IAC_CMA = '{iac: 1'b1, cma: 1'b1, default: 1'b0};

  logic                clk = 1'b0;
  logic                reset_n;
  logic [11:0]         base_addr;
  logic [MEM_OP_W-1:0] pdp_mem_opcode;
  logic [OP7_W-1:0]    pdp_op7_opcode;
  logic                stall;
  logic [11:0]         PC_value;
  logic                exec_rd_req;
  logic [11:0]         exec_rd_addr;
  logic [11:0]         exec_rd_data;
  logic                exec_wr_req;
  logic [11:0]         exec_wr_addr;
  logic [11:0]         exec_wr_data;
  logic [11:0]         ac_out;
  logic                link_out;
`ifdef EXEC_RETIRE_CNT_EN
  logic [31:0]         retire_cnt;
`endif

  instr_exec_lite #(.MEM_LAT(1), .OP7_CYCLES(2)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .base_addr      (base_addr),
    .pdp_mem_opcode (pdp_mem_opcode),
    .pdp_op7_opcode (pdp_op7_opcode),
    .stall          (stall),
    .PC_value       (PC_value),
    .exec_rd_req    (exec_rd_req),
    .exec_rd_addr   (exec_rd_addr),
    .exec_rd_data   (exec_rd_data),
    .exec_wr_req    (exec_wr_req),
    .exec_wr_addr   (exec_wr_addr),
    .exec_wr_data   (exec_wr_data),
    .ac_out         (ac_out),
    .link_out       (link_out)
`ifdef EXEC_RETIRE_CNT_EN
    ,
    .retire_cnt     (retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: data appears exactly one cycle after the read strobe.
  logic [11:0] mem [0:4095];
  logic        rd_valid_q = 1'b0;
  logic [11:0] rd_addr_q  = '0;
  assign exec_rd_data = rd_valid_q ? mem[rd_addr_q] : 12'o0000;

  int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
  logic [11:0] rd_last_addr = '0, wr_last_addr = '0, wr_last_data = '0;

  always @(posedge clk) begin
    rd_valid_q <= exec_rd_req;
    rd_addr_q  <= exec_rd_addr;
    if (exec_rd_req) begin
      rd_cnt       <= rd_cnt + 1;
      rd_last_addr <= exec_rd_addr;
    end
    if (exec_wr_req) begin
      wr_cnt       <= wr_cnt + 1;
      wr_last_addr <= exec_wr_addr;
      wr_last_data <= exec_wr_data;
    end
    if (exec_rd_req && exec_wr_req) both_cnt <= both_cnt + 1;
  end

  int   tests = 0;
  int   fails = 0;
  int   exp_retire = 0;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0o expected %0o", tag, obs, expv);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_stall"},   32'(stall),        32'd1);
    check({tag, "_pc"},      32'(PC_value),     32'o0);
    check({tag, "_ac"},      32'(ac_out),       32'o0);
    check({tag, "_link"},    32'(link_out),     32'd0);
    check({tag, "_rd_req"},  32'(exec_rd_req),  32'd0);
    check({tag, "_wr_req"},  32'(exec_wr_req),  32'd0);
    check({tag, "_wr_addr"}, 32'(exec_wr_addr), 32'o0);
    check({tag, "_wr_data"}, 32'(exec_wr_data), 32'o0);
`ifdef EXEC_RETIRE_CNT_EN
    check({tag, "_retire"},  retire_cnt,        32'd0);
`endif
  endtask

  // Drive one instruction in IDLE, push its expected outcome, wait for stall
  // to fall (bounded), then pop and compare.
  task automatic issue(input string tag, input logic [5:0] flags, input logic [11:0] addr,
                       input pdp_op7_opcode_s o7, input logic [11:0] e_pc,
                       input logic [11:0] e_ac, input logic e_link, input int e_cyc,
                       input int e_rds, input int e_wrs);
    int   n, rd0, wr0;
    exp_t e;
    @(negedge clk);
    check({tag, "_idle"}, 32'(stall), 32'd0);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    pdp_mem_opcode = {flags, addr};
    pdp_op7_opcode = o7;
    e = '{pc: e_pc, ac: e_ac, link: e_link, cycles: e_cyc, rds: e_rds, wrs: e_wrs};
    sb.push_back(e);
    exp_retire++;
    @(posedge clk);
    #1;
    pdp_mem_opcode = '0;
    pdp_op7_opcode = '0;
    n = 0;
    @(negedge clk);
    while (stall === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    e = sb.pop_front();
    check({tag, "_stall_cycles"}, 32'(n),           32'(e.cycles));
    check({tag, "_pc"},           32'(PC_value),    32'(e.pc));
    check({tag, "_ac"},           32'(ac_out),      32'(e.ac));
    check({tag, "_link"},         32'(link_out),    32'(e.link));
    check({tag, "_rd_count"},     32'(rd_cnt - rd0), 32'(e.rds));
    check({tag, "_wr_count"},     32'(wr_cnt - wr0), 32'(e.wrs));
`ifdef EXEC_RETIRE_CNT_EN
    check({tag, "_retire"},       retire_cnt,       32'(exp_retire));
`endif
  endtask

  initial begin
    int wr_before;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[12'o0100] = 12'o7777;
    mem[12'o0050] = 12'o7777;
    mem[12'o0051] = 12'o0005;
    mem[12'o0052] = 12'o1234;

    reset_n        = 1'b0;
    base_addr      = 12'o0200;
    pdp_mem_opcode = '0;
    pdp_op7_opcode = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");

    // T1: INIT cycle keeps stall high, then IDLE with PC at base_addr.
    reset_n = 1'b1;
    #1;
    check("init_stall", 32'(stall), 32'd1);
    @(negedge clk);
    check("idle_stall", 32'(stall), 32'd0);
    check("idle_pc", 32'(PC_value), 32'o0200);

    // T2: op7 sequence, plus RAR to set AC=0001 for the TAD case.
    issue("cla_cll", 6'b0, 12'o0, O_CLA_CLL, 12'o0201, 12'o0000, 1'b0, 2, 0, 0);
    issue("iac",     6'b0, 12'o0, O_IAC,     12'o0202, 12'o0001, 1'b0, 2, 0, 0);
    issue("ral",     6'b0, 12'o0, O_RAL,     12'o0203, 12'o0002, 1'b0, 2, 0, 0);
    issue("rar",     6'b0, 12'o0, O_RAR,     12'o0204, 12'o0001, 1'b0, 2, 0, 0);

    // T3: TAD overflow sets link.
    issue("tad", F_TAD, 12'o0100, O_NONE, 12'o0205, 12'o0000, 1'b1, 3, 1, 0);
    check("tad_rd_addr", 32'(rd_last_addr), 32'o0100);

    // T4: ISZ wrap skips; ISZ non-wrap does not.
    issue("isz_wrap", F_ISZ, 12'o0050, O_NONE, 12'o0207, 12'o0000, 1'b1, 4, 1, 1);
    check("isz_wrap_wr_addr", 32'(wr_last_addr), 32'o0050);
    check("isz_wrap_wr_data", 32'(wr_last_data), 32'o0000);
    issue("isz_inc", F_ISZ, 12'o0051, O_NONE, 12'o0210, 12'o0000, 1'b1, 4, 1, 1);
    check("isz_inc_wr_data", 32'(wr_last_data), 32'o0006);

    // AND / DCA and the remaining op7 forms.
    issue("cma", 6'b0, 12'o0, O_CMA, 12'o0211, 12'o7777, 1'b1, 2, 0, 0);
    issue("and", F_AND, 12'o0052, O_NONE, 12'o0212, 12'o1234, 1'b1, 3, 1, 0);
    issue("dca", F_DCA, 12'o0060, O_NONE, 12'o0213, 12'o0000, 1'b1, 2, 0, 1);
    check("dca_wr_addr", 32'(wr_last_addr), 32'o0060);
    check("dca_wr_data", 32'(wr_last_data), 32'o1234);
    issue("cml", 6'b0, 12'o0, O_CML, 12'o0214, 12'o0000, 1'b0, 2, 0, 0);
    issue("cia", 6'b0, 12'o0, O_CIA, 12'o0215, 12'o0000, 1'b1, 2, 0, 0);
    issue("rtl", 6'b0, 12'o0, O_RTL, 12'o0216, 12'o0002, 1'b0, 2, 0, 0);
    issue("rtr", 6'b0, 12'o0, O_RTR, 12'o0217, 12'o0000, 1'b1, 2, 0, 0);

    // T5: JMP / JMS, then PC wrap via op7 at 7777.
    issue("jmp", F_JMP, 12'o0200, O_NONE, 12'o0200, 12'o0000, 1'b1, 1, 0, 0);
    issue("jms", F_JMS, 12'o0300, O_NONE, 12'o0301, 12'o0000, 1'b1, 2, 0, 1);
    check("jms_wr_addr", 32'(wr_last_addr), 32'o0300);
    check("jms_wr_data", 32'(wr_last_data), 32'o0201);
    issue("jmp_top", F_JMP, 12'o7777, O_NONE, 12'o7777, 12'o0000, 1'b1, 1, 0, 0);
    issue("cll_wrap", 6'b0, 12'o0, O_CLL, 12'o0000, 12'o0000, 1'b0, 2, 0, 0);

    // All-zero opcodes are bubbles: nothing moves.
    repeat (3) @(negedge clk);
    check("bubble_stall", 32'(stall), 32'd0);
    check("bubble_pc", 32'(PC_value), 32'o0000);

    // T6 and other NOP forms; mem opcode priority over op7.
    issue("nop_multi_op7", 6'b0, 12'o0, O_IAC_CMA, 12'o0001, 12'o0000, 1'b0, 1, 0, 0);
    issue("nop_multi_mem", F_AND | F_TAD, 12'o0100, O_NONE, 12'o0002, 12'o0000, 1'b0, 1, 0, 0);
    issue("iac2", 6'b0, 12'o0, O_IAC, 12'o0003, 12'o0001, 1'b0, 2, 0, 0);
    issue("mem_priority", F_JMP, 12'o0400, O_CMA, 12'o0400, 12'o0001, 1'b0, 1, 0, 0);
    issue("nop_skip", 6'b0, 12'o0, O_SMA, 12'o0401, 12'o0001, 1'b0, 1, 0, 0);
    issue("nop_flag", 6'b0, 12'o0, O_NOP, 12'o0402, 12'o0001, 1'b0, 1, 0, 0);
    issue("cla", 6'b0, 12'o0, O_CLA, 12'o0403, 12'o0000, 1'b0, 2, 0, 0);
    check("rd_wr_overlap", 32'(both_cnt), 32'd0);

    // Reset during TAD: aborted, outputs back to reset values.
    @(negedge clk);
    wr_before = wr_cnt;
    pdp_mem_opcode = {F_TAD, 12'o0100};
    @(posedge clk);
    #1;
    pdp_mem_opcode = '0;
    @(negedge clk);
    check("tad_abort_rd_req", 32'(exec_rd_req), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("tad_abort");
    reset_n = 1'b1;
    exp_retire = 0;
    repeat (2) @(negedge clk);
    check("post_reset_pc", 32'(PC_value), 32'o0200);

    // Reset during ISZ before WR: the write must never appear.
    wr_before = wr_cnt;
    pdp_mem_opcode = {F_ISZ, 12'o0051};
    @(posedge clk);
    #1;
    pdp_mem_opcode = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("isz_abort");
    check("isz_abort_no_write", 32'(wr_cnt - wr_before), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
